// File: rtl/uart_arb_pkg.sv
// Shared constants and state encoding for the UART TX round-robin arbiter.
package uart_arb_pkg;

  // Upper bound on the number of producers sharing one serializer.
  localparam int MAX_REQ = 8;

  // Tag bytes are TAG_BASE + winner; 8'h30 makes tags read as ASCII '0'..'7'.
  localparam logic [7:0] TAG_BASE_DEF = 8'h30;

  // FSM encoding. TAG_WAIT is only reachable in the tagged build.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_LOAD     = 2'd1;
  localparam state_t ST_WAIT     = 2'd2;
  localparam state_t ST_TAG_WAIT = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches upward from
// last_grant+1 (wrapping) and reports the first requester with valid set.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] win_idx,
  output logic [NUM_REQ-1:0]         win_oh,
  output logic                       win_any
);
  localparam int IDXW = $clog2(NUM_REQ);

  // Scan farthest-to-nearest so the nearest valid requester overwrites the rest.
  always_comb begin
    int cand;
    cand    = 0;
    win_idx = '0;
    win_oh  = '0;
    win_any = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (req_valid[cand]) begin
        win_idx      = IDXW'(cand);
        win_oh       = '0;
        win_oh[cand] = 1'b1;
        win_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART_TX among NUM_REQ byte producers.
// One byte accepted per grant; re-arbitrates only after the serializer's Done.
// Optional feature: define UART_ARB_TAG_EN to precede every byte with a
// tag byte TAG_BASE + winner.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NUM_REQ  = 4,
  parameter int unsigned TAG_BASE = TAG_BASE_DEF
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_L,
  input  logic [NUM_REQ-1:0]         i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
  output logic [NUM_REQ-1:0]         o_Req_Ready,
  output logic                       o_TX_DV,
  output logic [7:0]                 o_TX_Byte,
  input  logic                       i_TX_Active,
  input  logic                       i_TX_Done,
  output logic                       o_Busy,
  output logic [$clog2(NUM_REQ)-1:0] o_Grant_Idx
);
  localparam int IDXW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TAG_BASE > 255) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TAG_BASE must fit in 8 bits");
  end

  state_t             state;
  logic [IDXW-1:0]    last_grant;
  logic [IDXW-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_any;
  logic               accept;
  logic [7:0]         win_byte;
  logic [7:0]         first_byte;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid  (i_Req_Valid),
    .last_grant (last_grant),
    .win_idx    (win_idx),
    .win_oh     (win_oh),
    .win_any    (win_any)
  );

  // Ready is offered only in IDLE; it is forced low while reset is held so
  // producers never see a handshake that the FSM cannot take.
  assign accept      = (state == ST_IDLE) && win_any;
  assign o_Req_Ready = (accept && i_Rst_L) ? win_oh : '0;
  assign win_byte    = i_Req_Byte[8*win_idx +: 8];
  assign o_Busy      = (state != ST_IDLE);

`ifdef UART_ARB_TAG_EN
  localparam logic [7:0] TAG8 = 8'(TAG_BASE);
  logic [7:0] data_q;      // data byte parked while the tag is on the wire
  logic       data_phase;  // current LOAD carries the data byte, not the tag
  assign first_byte = TAG8 + 8'(win_idx);
`else
  assign first_byte = win_byte;
`endif

  // Arbitration FSM. o_TX_DV is registered: it rises the cycle after the
  // edge that saw i_TX_Active low (at accept or later in LOAD) and lasts one cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= ST_IDLE;
      last_grant  <= IDXW'(NUM_REQ - 1);
      o_Grant_Idx <= '0;
      o_TX_DV     <= 1'b0;
      o_TX_Byte   <= 8'h00;
`ifdef UART_ARB_TAG_EN
      data_q      <= 8'h00;
      data_phase  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_grant  <= win_idx;
            o_Grant_Idx <= win_idx;
            o_TX_Byte   <= first_byte;
            o_TX_DV     <= !i_TX_Active;
            state       <= ST_LOAD;
`ifdef UART_ARB_TAG_EN
            data_q      <= win_byte;
            data_phase  <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (o_TX_DV) begin
            o_TX_DV <= 1'b0;
`ifdef UART_ARB_TAG_EN
            state   <= data_phase ? ST_WAIT : ST_TAG_WAIT;
`else
            state   <= ST_WAIT;
`endif
          end else if (!i_TX_Active) begin
            o_TX_DV <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_TX_Done) state <= ST_IDLE;
        end
`ifdef UART_ARB_TAG_EN
        ST_TAG_WAIT: begin
          if (i_TX_Done) begin
            state      <= ST_LOAD;
            o_TX_Byte  <= data_q;
            o_TX_DV    <= !i_TX_Active;
            data_phase <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ = 4).
// The serializer is stood in for by driving i_TX_Active / i_TX_Done by hand.
module tb_uart_tx_arbiter;
  localparam int N = 4;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic           i_Clock = 1'b0;
  logic           i_Rst_L;
  logic [N-1:0]   i_Req_Valid;
  logic [8*N-1:0] i_Req_Byte;
  logic [N-1:0]   o_Req_Ready;
  logic           o_TX_DV;
  logic [7:0]     o_TX_Byte;
  logic           i_TX_Active;
  logic           i_TX_Done;
  logic           o_Busy;
  logic [1:0]     o_Grant_Idx;

  uart_tx_arbiter #(.NUM_REQ(N), .TAG_BASE(8'h30)) dut (
    .i_Clock     (i_Clock),
    .i_Rst_L     (i_Rst_L),
    .i_Req_Valid (i_Req_Valid),
    .i_Req_Byte  (i_Req_Byte),
    .o_Req_Ready (o_Req_Ready),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (i_TX_Active),
    .i_TX_Done   (i_TX_Done),
    .o_Busy      (o_Busy),
    .o_Grant_Idx (o_Grant_Idx)
  );

  always #5 i_Clock = ~i_Clock;

  int         n_chk = 0;
  int         n_fail = 0;
  int         rdy_cnt = 0;
  logic [N-1:0] rdy_seen = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte expected on the first DV of a grant (tag in tagged builds).
  function automatic logic [7:0] first_byte(input int idx, input logic [7:0] b);
    return TAG_EN ? 8'(8'h30 + idx) : b;
  endfunction

  task automatic pulse_done();
    i_TX_Done = 1'b1;
    @(negedge i_Clock);
    i_TX_Done = 1'b0;
  endtask

  // Wait (bounded) for o_TX_DV, logging any ready seen on the way.
  task automatic wait_dv(input string tag);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (o_TX_DV) break;
      if (o_Req_Ready != '0) begin
        rdy_cnt++;
        rdy_seen |= o_Req_Ready;
      end
      @(negedge i_Clock);
    end
    check({tag, "/dv"}, 32'(o_TX_DV), 32'd1);
  endtask

  // From a DV cycle: confirm no further pulse/ready until Done, then finish.
  task automatic finish_grant(input string tag, input logic [7:0] b);
    logic quiet;
    quiet = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_Clock);
      quiet |= o_TX_DV | (|o_Req_Ready);
    end
    check({tag, "/quiet"}, 32'(quiet), 32'd0);
`ifdef UART_ARB_TAG_EN
    pulse_done();
    wait_dv({tag, "/data"});
    check({tag, "/data_byte"}, 32'(o_TX_Byte), 32'(b));
    @(negedge i_Clock);
`else
    if (b == 8'h00) quiet = 1'b0;
`endif
    pulse_done();
  endtask

  task automatic serve(input string tag, input int idx, input logic [7:0] b, input logic [N-1:0] drop);
    wait_dv(tag);
    check({tag, "/byte"}, 32'(o_TX_Byte), 32'(first_byte(idx, b)));
    check({tag, "/idx"}, 32'(o_Grant_Idx), 32'(idx));
    i_Req_Valid &= ~drop;
    finish_grant(tag, b);
  endtask

  task automatic set_byte(input int idx, input logic [7:0] b);
    i_Req_Byte[8*idx +: 8] = b;
  endtask

  initial begin
    logic seen;
    i_Rst_L = 1'b0; i_Req_Valid = '0; i_Req_Byte = '0;
    i_TX_Active = 1'b0; i_TX_Done = 1'b0;
    repeat (2) @(negedge i_Clock);
    #1;
    check("rst/dv",    32'(o_TX_DV),     32'd0);
    check("rst/byte",  32'(o_TX_Byte),   32'd0);
    check("rst/busy",  32'(o_Busy),      32'd0);
    check("rst/idx",   32'(o_Grant_Idx), 32'd0);
    @(negedge i_Clock);
    i_Rst_L = 1'b1;

    // Single requester 2 with 8'h41.
    @(negedge i_Clock);
    i_Req_Valid = 4'b0100; set_byte(2, 8'h41);
    #1 check("single/ready", 32'(o_Req_Ready), 32'h4);
    @(negedge i_Clock); #1;
    check("single/dv",    32'(o_TX_DV),     32'd1);
    check("single/byte",  32'(o_TX_Byte),   32'(first_byte(2, 8'h41)));
    check("single/ready0",32'(o_Req_Ready), 32'd0);
    check("single/busy",  32'(o_Busy),      32'd1);
    check("single/idx",   32'(o_Grant_Idx), 32'd2);
    i_Req_Valid = '0;
    finish_grant("single", 8'h41);
    #1 check("single/idle", 32'(o_Busy), 32'd0);

    // Full contention from reset: A0, A1, A2, A3, A0.
    i_Rst_L = 1'b0;
    i_Req_Valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_byte(i, 8'hA0 + 8'(i));
    @(negedge i_Clock);
    i_Rst_L = 1'b1;
    serve("cont0", 0, 8'hA0, 4'b0000);
    serve("cont1", 1, 8'hA1, 4'b0000);
    serve("cont2", 2, 8'hA2, 4'b0000);
    serve("cont3", 3, 8'hA3, 4'b0000);
    serve("cont4", 0, 8'hA0, 4'b1111);

    // Fairness between requesters 1 and 3.
    set_byte(1, 8'h11); set_byte(3, 8'h33);
    i_Req_Valid = 4'b1010;
    rdy_seen = '0;
    serve("fair0", 1, 8'h11, 4'b0000);
    serve("fair1", 3, 8'h33, 4'b0000);
    serve("fair2", 1, 8'h11, 4'b0000);
    serve("fair3", 3, 8'h33, 4'b1010);
    check("fair/rdy02", 32'(rdy_seen & 4'b0101), 32'd0);
    check("fair/rdy13", 32'(rdy_seen), 32'hA);

    // Active gating with a Done pulse while in LOAD.
    i_TX_Active = 1'b1;
    set_byte(1, 8'h5A); i_Req_Valid = 4'b0010;
    @(negedge i_Clock); #1;
    check("gate/busy", 32'(o_Busy), 32'd1);
    i_Req_Valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_Clock);
      i_TX_Done = (i == 5);
      #1 seen |= o_TX_DV;
    end
    check("gate/held_dv", 32'(seen),   32'd0);
    check("gate/load",    32'(o_Busy), 32'd1);
    @(negedge i_Clock);
    i_TX_Active = 1'b0;
    #1 check("gate/dv_same", 32'(o_TX_DV), 32'd0);
    @(negedge i_Clock); #1;
    check("gate/dv_next", 32'(o_TX_DV),     32'd1);
    check("gate/byte",    32'(o_TX_Byte),   32'(first_byte(1, 8'h5A)));
    check("gate/idx",     32'(o_Grant_Idx), 32'd1);
    finish_grant("gate", 8'h5A);

    // Spurious Done in IDLE must leave state and pointer untouched.
    pulse_done();
    #1;
    check("spur/busy", 32'(o_Busy),      32'd0);
    check("spur/idx",  32'(o_Grant_Idx), 32'd1);
    set_byte(0, 8'h70); set_byte(2, 8'h72);
    i_Req_Valid = 4'b0111;
    #1 check("spur/ready", 32'(o_Req_Ready), 32'h4);
    @(negedge i_Clock); #1;
    check("spur/dv",   32'(o_TX_DV),   32'd1);
    check("spur/byte", 32'(o_TX_Byte), 32'(first_byte(2, 8'h72)));
    i_Req_Valid = '0;
    finish_grant("spur", 8'h72);

`ifdef UART_ARB_TAG_EN
    // Tag then data for requester 2, single ready pulse, busy throughout.
    set_byte(2, 8'h55); i_Req_Valid = 4'b0100;
    rdy_cnt = 0;
    wait_dv("tag");
    check("tag/tag_byte", 32'(o_TX_Byte), 32'h32);
    i_Req_Valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_Clock);
      seen |= !o_Busy;
    end
    pulse_done();
    wait_dv("tag2");
    seen |= !o_Busy;
    check("tag/data_byte", 32'(o_TX_Byte), 32'h55);
    check("tag/busy_low",  32'(seen),      32'd0);
    check("tag/ready_cnt", 32'(rdy_cnt),   32'd1);
    @(negedge i_Clock);
    pulse_done();
    #1 check("tag/idle", 32'(o_Busy), 32'd0);
`endif

    // Reset while a frame is in flight; 0 and 3 valid.
    set_byte(0, 8'hC0); set_byte(3, 8'hC3);
    i_Req_Valid = 4'b1001;
    serve("rstw_a", 3, 8'hC3, 4'b0000);
    wait_dv("rstw_b");
    check("rstw_b/byte", 32'(o_TX_Byte), 32'(first_byte(0, 8'hC0)));
    i_TX_Active = 1'b1;
    @(negedge i_Clock);
    i_Rst_L = 1'b0;
    #1;
    check("rstw/dv",    32'(o_TX_DV),     32'd0);
    check("rstw/byte",  32'(o_TX_Byte),   32'd0);
    check("rstw/ready", 32'(o_Req_Ready), 32'd0);
    check("rstw/busy",  32'(o_Busy),      32'd0);
    check("rstw/idx",   32'(o_Grant_Idx), 32'd0);
    @(negedge i_Clock);
    i_Rst_L = 1'b1;
    #1 check("rstw/ready0", 32'(o_Req_Ready), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_Clock);
      #1 seen |= o_TX_DV;
    end
    check("rstw/held_dv", 32'(seen),        32'd0);
    check("rstw/idx0",    32'(o_Grant_Idx), 32'd0);
    i_TX_Active = 1'b0;
    @(negedge i_Clock); #1;
    check("rstw/dv_after", 32'(o_TX_DV),   32'd1);
    check("rstw/byte0",    32'(o_TX_Byte), 32'(first_byte(0, 8'hC0)));
    i_Req_Valid = '0;
    finish_grant("rstw", 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
